// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer:
// FSM states, redirect-source encoding, PC increment and reset vector.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_J    = 2'd2,
        SRC_JR   = 2'd3
    } redir_src_e;

    localparam logic [31:0] PC_INC            = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;

    // Sign-extended branch offset in bytes (immediate is a word offset).
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_jump_target_calc.sv
// Combinational redirect target calculation and priority select.
// Ports: branch/jump/jr requests in; selected source, target and
// JR misalignment flag out. With PC_DELAY_SLOT_EN defined, also
// reports the PC of the redirecting instruction (src_pc_o).
module jump_target_calc
    import pc_seq_pkg::*;
(
    input  logic        branch_taken_i,
    input  logic [31:0] branch_pc_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_pc_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_en_i,
    input  logic [31:0] jr_target_i,
`ifdef PC_DELAY_SLOT_EN
    output logic [31:0] src_pc_o,
`endif
    output logic [1:0]  src_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic [31:0] br_tgt;
    logic [31:0] j_slot;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;

    assign br_tgt     = branch_pc_i + PC_INC + br_offset(branch_imm_i);
    // Jump region comes from the delay-slot PC, not the jump itself.
    assign j_slot     = jump_pc_i + PC_INC;
    assign j_tgt      = {j_slot[31:28], jump_index_i, 2'b00};
    assign jr_tgt     = {jr_target_i[31:2], 2'b00};
    assign misalign_o = jr_target_i[1:0] != 2'b00;

    always_comb begin
        src_o    = SRC_NONE;
        target_o = br_tgt;
        if (jr_en_i) begin
            src_o    = SRC_JR;
            target_o = jr_tgt;
        end else if (jump_en_i) begin
            src_o    = SRC_J;
            target_o = j_tgt;
        end else if (branch_taken_i) begin
            src_o    = SRC_BR;
            target_o = br_tgt;
        end
    end

`ifdef PC_DELAY_SLOT_EN
    always_comb begin
        src_pc_o = branch_pc_i;
        if (jump_en_i) begin
            src_pc_o = jump_pc_i;
        end
    end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: sequential increment, branch/J/JR redirects,
// fetch handshake and IF/ID flush. Optional macro PC_DELAY_SLOT_EN
// enables MIPS delay-slot handling (PENDING state, no flush).
// Ports: clk, rst_n, stall_i, if_ready_i, fetch_valid_o, fetch_pc_o,
// branch_*_i, jump_*_i, jr_*_i, flush_o, addr_err_o.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        if_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_pc_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_pc_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_en_i,
    input  logic [31:0] jr_target_i,
    output logic        flush_o,
    output logic        addr_err_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        aerr_q, aerr_d;

    logic [1:0]  src;
    logic [31:0] target;
    logic        misalign;
    logic        redir;
    logic        transfer;
    logic        hold_slot;

`ifdef PC_DELAY_SLOT_EN
    logic [31:0] src_pc;
    logic [31:0] tgt_q, tgt_d;
`endif

    jump_target_calc u_calc (
        .branch_taken_i (branch_taken_i),
        .branch_pc_i    (branch_pc_i),
        .branch_imm_i   (branch_imm_i),
        .jump_en_i      (jump_en_i),
        .jump_pc_i      (jump_pc_i),
        .jump_index_i   (jump_index_i),
        .jr_en_i        (jr_en_i),
        .jr_target_i    (jr_target_i),
`ifdef PC_DELAY_SLOT_EN
        .src_pc_o       (src_pc),
`endif
        .src_o          (src),
        .target_o       (target),
        .misalign_o     (misalign)
    );

    assign redir    = (src != SRC_NONE) && (state_q != ST_BOOT);
    assign transfer = fetch_valid_o & if_ready_i;

`ifdef PC_DELAY_SLOT_EN
    // Defer only while the delay slot is still the unaccepted fetch.
    // JR resolves late enough that its slot is always already fetched.
    assign hold_slot = redir && (src != SRC_JR)
                     && (pc_q == src_pc + PC_INC) && !transfer;
`else
    assign hold_slot = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            aerr_q  <= aerr_d;
        end
    end

`ifdef PC_DELAY_SLOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q <= RESET_VECTOR;
        end else begin
            tgt_q <= tgt_d;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_PENDING: begin
                if (hold_slot) begin
                    state_d = ST_PENDING;
                end else if (redir) begin
                    state_d = ST_RUN;
                end else if (transfer) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // PC and pulse datapath
    always_comb begin
        pc_d   = pc_q;
        aerr_d = redir && (src == SRC_JR) && misalign;
`ifdef PC_DELAY_SLOT_EN
        flush_d = 1'b0;
        tgt_d   = tgt_q;
        if (hold_slot) begin
            tgt_d = target;
        end else if (redir) begin
            pc_d = target;
        end else if (transfer && state_q == ST_PENDING) begin
            pc_d = tgt_q;
        end else if (transfer) begin
            pc_d = pc_q + PC_INC;
        end
`else
        flush_d = redir;
        if (redir) begin
            pc_d = target;
        end else if (transfer) begin
            pc_d = pc_q + PC_INC;
        end
`endif
    end

    // Outputs
    always_comb begin
        fetch_valid_o = (state_q != ST_BOOT) && !stall_i;
        fetch_pc_o    = pc_q;
        flush_o       = flush_q;
        addr_err_o    = aerr_q;
    end

endmodule
